// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state/op types and the default SDRAM address/data widths
// used by the arbiter and the record/play cores.
package sdram_arb_pkg;
    localparam int DEF_ADDR_W = 23;
    localparam int DEF_DATA_W = 32;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {OP_READ, OP_WRITE} op_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker; returns the first pending index
// after i_ptr, wrapping around.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    localparam int GW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_pend,
    input  logic [GW-1:0]      i_ptr,
    output logic [GW-1:0]      o_grant,
    output logic               o_valid
);
    logic [GW-1:0] w_idx;
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = i_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (w_idx == GW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            if (!o_valid && i_pend[w_idx]) begin
                o_grant = w_idx;
                o_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin sharing of one SDRAM port among NUM_REQ cores.
// Define SDRAM_ARB_TIMEOUT_EN to add the BUSY watchdog and sticky timeout_err.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = 1024,
    localparam int GW = $clog2(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
    output logic [DATA_W-1:0]         req_readdata,
    output logic [NUM_REQ-1:0]        req_finished,
    output logic                      sdram_read,
    output logic                      sdram_write,
    output logic [ADDR_W-1:0]         sdram_addr,
    output logic [DATA_W-1:0]         sdram_writedata,
    input  logic [DATA_W-1:0]         sdram_readdata,
    input  logic                      sdram_finished,
    output logic [GW-1:0]             grant_id,
    output logic                      busy,
    output logic                      timeout_err
);
    state_t              r_state, w_next;
    op_t                 r_op;
    logic [GW-1:0]       r_ptr, r_grant, w_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata, r_rdata;
    logic [NUM_REQ-1:0]  w_pend;
    logic                w_valid, w_tmo, w_done;

    assign w_pend = req_read | req_write;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_pend  (w_pend),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] r_cnt;
    logic          r_tmo_err;
    assign w_tmo = (r_state == BUSY) && !sdram_finished && (r_cnt == CW'(TIMEOUT_CYC - 1));
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            r_cnt <= (r_state == BUSY) ? r_cnt + 1'b1 : '0;
            if (w_tmo)
                r_tmo_err <= 1'b1;
        end
    end
    assign timeout_err = r_tmo_err;
`else
    assign w_tmo       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign w_done = sdram_finished || w_tmo;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (w_valid ? BUSY : IDLE) :
                 (r_state == BUSY) ? (w_done ? RESP : BUSY) : IDLE;
    end

    // Both read and write high means write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr   <= GW'(NUM_REQ - 1);
            r_grant <= '0;
            r_op    <= OP_READ;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == IDLE && w_valid) begin
                r_grant <= w_grant;
                r_op    <= req_write[w_grant] ? OP_WRITE : OP_READ;
                r_addr  <= req_addr[w_grant*ADDR_W +: ADDR_W];
                r_wdata <= req_writedata[w_grant*DATA_W +: DATA_W];
            end
            if (r_state == BUSY && w_done)
                r_rdata <= (r_op == OP_READ && !w_tmo) ? sdram_readdata : '0;
            if (r_state == RESP)
                r_ptr <= r_grant;
        end
    end

    assign busy            = (r_state != IDLE);
    assign sdram_read      = (r_state == BUSY) && (r_op == OP_READ);
    assign sdram_write     = (r_state == BUSY) && (r_op == OP_WRITE);
    assign sdram_addr      = r_addr;
    assign sdram_writedata = r_wdata;
    assign grant_id        = r_grant;
    assign req_readdata    = r_rdata;
    assign req_finished    = (r_state == RESP) ? (NUM_REQ'(1) << r_grant) : '0;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed and randomized transactions checked against a
// transaction-level round-robin model.
module tb_sdram_arbiter;
    localparam int N  = 3;
    localparam int AW = 23;
    localparam int DW = 32;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N-1:0]          rr, rw;
    logic [N-1:0][AW-1:0]  ra;
    logic [N-1:0][DW-1:0]  rwd;
    logic [DW-1:0]         rdata, sd_rdata, sd_wd;
    logic [N-1:0]          fin;
    logic                  sd_rd, sd_wr, sd_fin, busy, terr;
    logic [AW-1:0]         sd_addr;
    logic [1:0]            gid;
    int                    n_vec = 0;
    int                    n_err = 0;
    int                    ptr = N - 1;

    always #5 clk = ~clk;

    sdram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .req_read        (rr),
        .req_write       (rw),
        .req_addr        (ra),
        .req_writedata   (rwd),
        .req_readdata    (rdata),
        .req_finished    (fin),
        .sdram_read      (sd_rd),
        .sdram_write     (sd_wr),
        .sdram_addr      (sd_addr),
        .sdram_writedata (sd_wd),
        .sdram_readdata  (sd_rdata),
        .sdram_finished  (sd_fin),
        .grant_id        (gid),
        .busy            (busy),
        .timeout_err     (terr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first pending requester after the last owner.
    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
            int i = (ptr + k) % N;
            if (rr[i] || rw[i])
                return i;
        end
        return -1;
    endfunction

    // One full transaction from IDLE back to IDLE; lat = extra BUSY cycles.
    task automatic txn(input int lat, input logic [DW-1:0] rdv, output int g);
        bit            wr;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        g  = pick();
        wr = rw[g];
        ea = ra[g];
        ed = rwd[g];
        tick();
        chk("busy", busy, 1);
        chk("grant", gid, g);
        chk("rd_cmd", sd_rd, !wr);
        chk("wr_cmd", sd_wr, wr);
        chk("addr", sd_addr, ea);
        if (wr)
            chk("wdata", sd_wd, ed);
        ra[g]  = AW'($urandom);
        rwd[g] = $urandom;
        for (int c = 0; c < lat; c++) begin
            tick();
            chk("hold_addr", sd_addr, ea);
            chk("hold_cmd", {sd_rd, sd_wr}, {!wr, wr});
            chk("no_fin", fin, 0);
        end
        sd_rdata = rdv;
        sd_fin   = 1'b1;
        tick();
        sd_fin   = 1'b0;
        sd_rdata = $urandom;
        chk("fin", fin, 64'(1) << g);
        chk("rdata", rdata, wr ? 0 : rdv);
        chk("cmd_off", {sd_rd, sd_wr}, 0);
        rr[g] = 1'b0;
        rw[g] = 1'b0;
        ptr   = g;
        tick();
        chk("idle", busy, 0);
        chk("fin_once", fin, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int         g;
        logic [1:0] r;
        rr = '0; rw = '0; ra = '0; rwd = '0; sd_rdata = '0; sd_fin = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_cmd", {sd_rd, sd_wr}, 0);
        chk("rst_addr", sd_addr, 0);
        chk("rst_wdata", sd_wd, 0);
        chk("rst_fin", fin, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_gid", gid, 0);
        chk("rst_terr", terr, 0);
        rst_n = 1'b1;
        tick();

        rr[1] = 1'b1;
        ra[1] = 23'h000123;
        txn(4, 32'hDEADBEEF, g);
        chk("single_grant", g, 1);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ptr = N - 1;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++)
                if (!(rr[i] || rw[i])) begin
                    rw[i]  = 1'b1;
                    ra[i]  = AW'(i + 16 * t);
                    rwd[i] = 32'hA000_0000 + i;
                end
            txn($urandom_range(0, 3), $urandom, g);
            chk("rr_order", g, t % 3);
        end
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < N; i++) begin
                if (rw[i]) txn(0, $urandom, g);
            end
        end

        rr[0] = 1'b1; rw[0] = 1'b1; rwd[0] = 32'h1234_5678; ra[0] = 23'h7_0000;
        txn(2, 32'hFFFF_FFFF, g);
        chk("both_grant", g, 0);

        rr[2] = 1'b1; ra[2] = 23'h55_AAAA;
        txn(3, 32'h0BAD_F00D, g);
        chk("addr_change_grant", g, 2);

        rw[2] = 1'b1; ra[2] = 23'h12_3456; rwd[2] = 32'hCAFE_0002;
        tick();
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmd", {sd_rd, sd_wr}, 0);
        chk("mid_rst_addr", sd_addr, 0);
        chk("mid_rst_gid", gid, 0);
        sd_fin = 1'b1;
        tick();
        sd_fin = 1'b0;
        chk("mid_rst_fin", fin, 0);
        rr[0] = 1'b1; ra[0] = 23'h00_0777;
        rst_n = 1'b1;
        ptr = N - 1;
        txn(1, 32'h7777_0000, g);
        chk("post_rst_first", g, 0);
        txn(0, 32'h0, g);
        chk("post_rst_second", g, 2);

        for (int t = 0; t < 200; t++) begin
            for (int i = 0; i < N; i++)
                if (!(rr[i] || rw[i]) && $urandom_range(0, 1) == 1) begin
                    r      = 2'($urandom_range(1, 3));
                    rr[i]  = r[0];
                    rw[i]  = r[1];
                    ra[i]  = AW'($urandom);
                    rwd[i] = $urandom;
                end
            if (pick() < 0) begin
                rr[t % N] = 1'b1;
                ra[t % N] = AW'($urandom);
            end
            txn($urandom_range(0, 5), $urandom, g);
        end

`ifdef SDRAM_ARB_TIMEOUT_EN
        rr[1] = 1'b1; ra[1] = 23'h00_0005;
        g = pick();
        tick();
        chk("tmo_cmd", sd_rd, 1);
        for (int c = 0; c < 15; c++) begin
            tick();
            chk("tmo_hold", sd_rd, 1);
        end
        tick();
        chk("tmo_fin", fin, 64'(1) << g);
        chk("tmo_rdata", rdata, 0);
        chk("tmo_cmd_off", {sd_rd, sd_wr}, 0);
        chk("tmo_err", terr, 1);
        rr[1] = 1'b0;
        ptr = g;
        tick();
        tick();
        chk("tmo_sticky", terr, 1);
`else
        chk("terr_off", terr, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single SDRAM access port among several audio cores: record, playback, and any later requester. Each requester sees the same read/write/address/finished handshake the cores already use toward SDRAM. The arbiter serializes requests with round-robin priority, forwards one transaction at a time to the SDRAM controller, and routes the completion back to the owner. It sits between the audio cores and the SDRAM controller wrapper.

## Interface
- NUM_REQ, 3, number of requesters (index 0 = record, 1 = play, 2 = spare)
- ADDR_W, 23, SDRAM word address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the macro)

- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous, active-low reset
- req_read  in  NUM_REQ  per-requester read request, level, held until its finished pulse
- req_write  in  NUM_REQ  per-requester write request, level, held until its finished pulse
- req_addr  in  NUM_REQ x ADDR_W  per-requester address
- req_writedata  in  NUM_REQ x DATA_W  per-requester write data
- req_readdata  out  DATA_W  shared read-return data, valid while the owner's finished bit is high
- req_finished  out  NUM_REQ  one-hot, one-cycle completion pulse
- sdram_read  out  1  read command to the SDRAM controller
- sdram_write  out  1  write command to the SDRAM controller
- sdram_addr  out  ADDR_W  SDRAM address
- sdram_writedata  out  DATA_W  SDRAM write data
- sdram_readdata  in  DATA_W  SDRAM read data
- sdram_finished  in  1  SDRAM transaction complete, one-cycle pulse
- grant_id  out  $clog2(NUM_REQ)  index of the current or last owner
- busy  out  1  high in BUSY and RESP
- timeout_err  out  1  sticky watchdog flag; tied to 0 without the macro

## Operation
- Reset values:
  - all outputs 0
  - state IDLE
  - last-grant pointer NUM_REQ-1, so requester 0 has first priority
- A requester is pending when req_read[i] or req_write[i] is high.
- If both bits are high for one requester, the arbiter treats the request as a write.
- States:
  - IDLE:
    - If any requester is pending, pick the first pending index searching from pointer+1 upward with wrap.
    - Latch index, op, addr and writedata into registers.
    - Go to BUSY. No pending requester: stay in IDLE.
  - BUSY:
    - Drive sdram_read or sdram_write from the latched op, plus the latched addr and writedata.
    - Commands hold steady until sdram_finished.
    - On sdram_finished: capture sdram_readdata (writes capture 0), go to RESP.
  - RESP:
    - req_finished[grant]=1 for exactly one cycle; req_readdata = captured data.
    - sdram_* commands are 0.
    - Pointer <= grant. Go to IDLE.
- Requester inputs are sampled only in IDLE. Changes during BUSY/RESP are ignored.
- A requester that drops its request before being granted is simply skipped.
- A requester must deassert on the edge where it samples its finished pulse. Otherwise it is treated as a new request and competes again in IDLE.
- Reset mid-transaction: immediate return to reset values. In-flight transaction is abandoned with no finished pulse.

## Timing
- Request visible in IDLE at cycle 0 -> sdram command asserted at cycle 1.
- sdram_finished at cycle k -> req_finished at cycle k+1.
- Minimum request-to-finished latency: 2 cycles, when sdram_finished arrives in the first BUSY cycle.
- One idle cycle between transactions. Peak throughput is one transaction per 3 cycles.
- Fairness: every pending requester is granted within NUM_REQ-1 other transactions.
- All outputs are registered or decoded directly from registered state. No input-to-output combinational path.

## Configuration
- SDRAM_ARB_TIMEOUT_EN defined:
  - Counter runs in BUSY.
  - If TIMEOUT_CYC cycles pass without sdram_finished: drop commands, go to RESP with readdata 0, set timeout_err.
  - timeout_err stays set until reset.
- Undefined: BUSY waits indefinitely and timeout_err is constant 0.

## Structure
- sdram_arb_pkg holds:
  - state enum {IDLE, BUSY, RESP}
  - op typedef {OP_READ, OP_WRITE}
  - default ADDR_W/DATA_W constants shared with the record and play cores
- Sub-module rr_arbiter: combinational round-robin picker.
  - Inputs: pending vector, pointer.
  - Outputs: grant index, any_valid.
  - Instanced once.

## Test plan
- Single read, requester 1, addr 0x000123; SDRAM finishes 4 cycles after command, data 0xDEADBEEF -> req_finished[1] pulses once, req_readdata=0xDEADBEEF, sdram_addr=0x000123 while busy.
- Requesters 0, 1, 2 all request writes continuously after reset -> grant order 0,1,2,0,1,2; each sdram_writedata matches its owner's data.
- Requester 0 asserts both read and write -> sdram_write only, sdram_read never high.
- Requester 2 changes req_addr during BUSY -> sdram_addr keeps the latched value.
- i_rst_n low in BUSY -> all outputs 0 at once; no finished pulse; after release, requester 0 wins first.
- With SDRAM_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, SDRAM never finishes -> commands drop after 16 cycles, finished pulse with readdata 0, timeout_err=1 and sticky.
